// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Helpers work on vectors of MAX_PORTS bits so they serve any NUM_PORTS in 2..8.
package dmem_arb_pkg;

    localparam int MAX_PORTS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LOCKED
    } arb_state_t;

    // First set bit of req at or after ptr, in modulo-n order, as a one-hot vector.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [IDX_W-1:0]     ptr,
        input int                   n
    );
        logic [MAX_PORTS-1:0] oh;
        bit                   found;
        int                   idx;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx]) begin
                    oh[idx] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_PORTS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (oh[k]) idx = idx | IDX_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side bus of the data-memory arbiter: requests in, grants and read returns out.
interface dmem_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS-1:0]        lock;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        gnt;
    logic [NUM_PORTS-1:0]        addr_err;
    logic [NUM_PORTS-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, addr_err, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, addr_err, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_priority_picker.sv
// Round-robin picker: rotate requests so ptr sits at bit 0, keep the lowest set bit,
// then rotate back. Purely combinational.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);
    logic [N-1:0] rot;
    logic [N-1:0] rot_pick;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [PW:0] fwd;
            logic [PW:0] back;
            always_comb begin
                fwd = {1'b0, ptr} + (PW+1)'(gi);
                if (fwd >= (PW+1)'(N)) fwd = fwd - (PW+1)'(N);
                back = (PW+1)'(gi) + (PW+1)'(N) - {1'b0, ptr};
                if (back >= (PW+1)'(N)) back = back - (PW+1)'(N);
            end
            assign rot[gi]  = req[fwd[PW-1:0]];
            assign pick[gi] = rot_pick[back[PW-1:0]];
        end
    endgenerate

    // Two's-complement trick isolates the lowest set bit.
    assign rot_pick = rot & (~rot + N'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between NUM_PORTS cores,
// with per-port lock for read-modify-write sequences.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int RAM_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         bus,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  busy
);
    localparam int PTR_W = $clog2(NUM_PORTS);

    arb_state_t            state_reg;
    logic [PTR_W-1:0]      rr_ptr_reg;
    logic [PTR_W-1:0]      owner_reg;
    logic [NUM_PORTS-1:0]  gnt_reg;
    logic [NUM_PORTS-1:0]  addr_err_reg;
    logic [NUM_PORTS-1:0]  pend_rd_reg;
    logic [NUM_PORTS-1:0]  rvalid_reg;
    logic [RAM_ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0]     ram_wdata_reg;
    logic                  ram_we_reg;
    logic                  busy_reg;

    logic [ADDR_W-1:0]     port_addr  [NUM_PORTS];
    logic [DATA_W-1:0]     port_wdata [NUM_PORTS];
    logic [NUM_PORTS-1:0]  addr_hi_err;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_addr[gi]   = bus.addr[gi*ADDR_W +: ADDR_W];
            assign port_wdata[gi]  = bus.wdata[gi*DATA_W +: DATA_W];
            assign addr_hi_err[gi] = |port_addr[gi][ADDR_W-1:RAM_ADDR_W];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_PORTS-1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [NUM_PORTS-1:0] owner_oh;
    logic                 locked_hold;
    logic [NUM_PORTS-1:0] eff_req;
    logic [PTR_W-1:0]     eff_ptr;
    logic [NUM_PORTS-1:0] win_oh;
    logic [PTR_W-1:0]     win_idx;
    logic                 grant_any;

    // While the owner keeps lock high only its request is visible; on lock release the
    // search restarts just after the owner.
    assign owner_oh    = NUM_PORTS'(1) << owner_reg;
    assign locked_hold = (state_reg == LOCKED) && |(bus.lock & owner_oh);
    assign eff_req     = locked_hold ? (bus.req & owner_oh) : bus.req;
    assign eff_ptr     = (state_reg == LOCKED) ? inc_ptr(owner_reg) : rr_ptr_reg;
    assign grant_any   = |win_oh;
    assign win_idx     = PTR_W'(onehot2idx(MAX_PORTS'(win_oh)));

    rr_priority_picker #(
        .N  (NUM_PORTS),
        .PW (PTR_W)
    ) u_picker (
        .req  (eff_req),
        .ptr  (eff_ptr),
        .pick (win_oh)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            gnt_reg       <= '0;
            addr_err_reg  <= '0;
            pend_rd_reg   <= '0;
            rvalid_reg    <= '0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            ram_we_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            gnt_reg      <= win_oh;
            addr_err_reg <= win_oh & addr_hi_err;
            ram_we_reg   <= grant_any && bus.we[win_idx];
            pend_rd_reg  <= (grant_any && !bus.we[win_idx]) ? win_oh : '0;
            rvalid_reg   <= pend_rd_reg;
            if (grant_any) begin
                ram_addr_reg  <= port_addr[win_idx][RAM_ADDR_W-1:0];
                ram_wdata_reg <= port_wdata[win_idx];
            end

            if (locked_hold) begin
                state_reg <= LOCKED;
                busy_reg  <= 1'b1;
            end else if (grant_any) begin
                rr_ptr_reg <= inc_ptr(win_idx);
                busy_reg   <= 1'b1;
                if (bus.lock[win_idx]) begin
                    state_reg <= LOCKED;
                    owner_reg <= win_idx;
                end else begin
                    state_reg <= ISSUE;
                end
            end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                if (state_reg == LOCKED) rr_ptr_reg <= inc_ptr(owner_reg);
            end
        end
    end

    assign bus.gnt      = gnt_reg;
    assign bus.addr_err = addr_err_reg;
    assign bus.rvalid   = rvalid_reg;
    assign bus.rdata    = (|rvalid_reg) ? ram_rdata : '0;
    assign ram_addr     = ram_addr_reg;
    assign ram_wdata    = ram_wdata_reg;
    assign ram_we       = ram_we_reg;
    assign busy         = busy_reg;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares the single-port data RAM between NUM_PORTS GPP cores in the multi-core build.
- Sits between the cores' data-memory ports (address_rw / data_in / memory_write_enable / data_out) and one RAM instance.
- Issues at most one RAM access per cycle and returns read data with a per-port valid strobe.
- Supports a per-port lock so a core can hold the RAM across a read-modify-write sequence.

Parameters:
- NUM_PORTS, 4, number of requesting cores (2..8).
- DATA_W, 16, data word width.
- ADDR_W, 16, core-side address width.
- RAM_ADDR_W, 5, RAM address width; the RAM holds 2^RAM_ADDR_W words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req  in  NUM_PORTS  per-port access request; the requester holds it until its gnt bit is seen.
- we  in  NUM_PORTS  per-port write enable; 1 = write, 0 = read.
- lock  in  NUM_PORTS  per-port hold-grant request.
- addr  in  NUM_PORTS*ADDR_W  packed per-port addresses; port i occupies slice [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  packed per-port write data.
- gnt  out  NUM_PORTS  one-hot, 1-cycle pulse: the request was accepted.
- addr_err  out  NUM_PORTS  pulses with gnt when upper address bits are nonzero.
- rvalid  out  NUM_PORTS  one-hot, 1-cycle pulse: rdata belongs to this port.
- rdata  out  DATA_W  read data, common to all ports.
- ram_addr  out  RAM_ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after ram_addr is presented.
- busy  out  1  high while the FSM is in ISSUE or LOCKED.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; rr_ptr=0; FSM=IDLE; pending read dropped; lock owner cleared.
- Registered outputs: every output except rdata is registered.
- Arbitration (each cycle in IDLE or ISSUE):
  - Winner = first requesting port at or after rr_ptr, in modulo order.
  - On a grant, rr_ptr <= winner+1 mod NUM_PORTS.
  - Winner's addr[RAM_ADDR_W-1:0], wdata and we are registered onto ram_*; gnt[winner] pulses in the same cycle they appear.
- Read latency:
  - ram_* driven in cycle T → rvalid[winner]=1 in T+1.
  - rdata = ram_rdata combinationally, gated to 0 when no rvalid bit is set.
  - Throughput: one access per cycle; back-to-back reads from different ports overlap.
- Writes: no rvalid pulse; ram_we=1 for exactly one cycle per granted write.
- No request: ram_we=0; ram_addr and ram_wdata hold their last value.
- Address range: any of addr bits [ADDR_W-1:RAM_ADDR_W] nonzero → address truncated, access still performed, addr_err[winner] pulses with gnt.
- FSM:
  - IDLE: no grant last cycle. Any req → ISSUE.
  - ISSUE: grant made this cycle.
    - lock[winner]=1 at grant → LOCKED, lock owner = winner.
    - Else any req → ISSUE.
    - Else → IDLE.
  - LOCKED: only the owner may be granted; other ports stall.
    - Owner req → grant and stay.
    - Owner lock drops → ISSUE if any req is pending, else IDLE.
    - rr_ptr is not advanced while LOCKED; on exit it is set to owner+1.
- Simultaneous events:
  - A port deasserting req in the same cycle it would win is not granted.
  - req and lock both rising together is granted normally, then the FSM enters LOCKED.
- Reset mid-read: the rvalid for the in-flight read is suppressed.

Decomposition:
- Package dmem_arb_pkg:
  - typedef arb_state_t {IDLE, ISSUE, LOCKED}.
  - Functions: rr_pick(req, ptr) returning a one-hot vector; onehot2idx.
- One sub-module, rr_priority_picker: combinational rotate, priority-encode, and unrotate over NUM_PORTS.

Test Plan:
1. Single read: port0 req, addr=0x0003, RAM[3]=0xBEEF → gnt[0] in cycle 1, ram_addr=3; rvalid[0]=1 and rdata=0xBEEF in cycle 2.
2. Fairness: all 4 ports hold req for 8 cycles → grant order 0,1,2,3,0,1,2,3; each port gets exactly 2 grants.
3. Write then read: port2 writes 0x1234 to addr 7, then port1 reads addr 7 → ram_we=1 for exactly one cycle; port1 receives rdata=0x1234 with rvalid[1].
4. Lock: port1 asserts req+lock for 3 accesses while ports 0 and 3 request → ports 0 and 3 see no gnt during those 3 cycles; after lock drops, next grant goes to port 3 (rr_ptr=2, port 2 idle), then port 0.
5. Address error: port3 reads addr 0x0025 → ram_addr=0x05, addr_err[3] pulses with gnt[3], read completes normally.
6. Reset mid-operation: rst driven low in the cycle after a read grant → rvalid stays 0; all outputs 0; after release, a port0 req is granted first (rr_ptr=0).
